// File: rtl/timing_control_pkg.sv
// timing_control_pkg: shared CPU timing constants, vector codes and state encoding
package timing_control_pkg;
    typedef enum logic [1:0] {
        RST_HOLD = 2'd0,
        RST_SEQ  = 2'd1,
        RUN      = 2'd2
    } state_t;
    localparam logic [7:0] BRK_OP      = 8'h00;
    localparam logic [1:0] VEC_NONE    = 2'b00;
    localparam logic [1:0] VEC_NMI     = 2'b01;
    localparam logic [1:0] VEC_RESET   = 2'b10;
    localparam logic [1:0] VEC_IRQ     = 2'b11;
    localparam logic [2:0] RESET_CYCLE = 3'd7;
    localparam int         RST_SEQ_LEN = 6;
    localparam logic [2:0] SEQ_LAST    = 3'(RST_SEQ_LEN - 1);
endpackage

// File: rtl/timing_control_nmi_edge_latch.sv
// nmi_edge_latch: NMI falling-edge detector with a pending latch cleared on injection
module nmi_edge_latch (
    input  logic clk_ph2,
    input  logic rst,
    input  logic nmi_n,
    input  logic clear,
    output logic pending
);
    logic nmi_q;

    // Sample nmi_n every edge; a fresh falling edge wins over a same-edge clear
    always_ff @(posedge clk_ph2)
        if (!rst) begin
            nmi_q   <= 1'b1;
            pending <= 1'b0;
        end else begin
            nmi_q   <= nmi_n;
            pending <= (nmi_q & ~nmi_n) | (pending & ~clear);
        end
endmodule

// File: rtl/timing_control.sv
// timing_control: instruction cycle counter, IR load and reset/interrupt injection for the CPU core
module timing_control
    import timing_control_pkg::*;
(
    input  logic       clk_ph2,
    input  logic       rst,
    input  logic       I_cycle,
    input  logic       R_cycle,
    input  logic [7:0] DL,
    input  logic       rdy,
    input  logic       nmi_n,
    input  logic       irq_n,
    input  logic       I_flag,
    output logic [2:0] cycle,
    output logic [7:0] IR,
    output logic       sync,
    output logic       int_inject,
    output logic [1:0] vec_sel,
    output logic       reset_active
);
    state_t     state, state_nxt;
    logic [2:0] seq, seq_nxt;
    logic       nmi_pending, load, take_nmi, take_irq;

    nmi_edge_latch u_nmi (
        .clk_ph2 (clk_ph2),
        .rst     (rst),
        .nmi_n   (nmi_n),
        .clear   (take_nmi),
        .pending (nmi_pending)
    );

    // State and reset-sequence counter; rdy low freezes both
    always_ff @(posedge clk_ph2)
        if (!rst) begin
            state <= RST_HOLD;
            seq   <= '0;
        end else if (rdy) begin
            state <= state_nxt;
            seq   <= seq_nxt;
        end

    // Next state: leave hold on release, count out the reset sequence, then run
    always_comb begin
        state_nxt = state;
        seq_nxt   = '0;
        case (state)
            RST_HOLD: state_nxt = RST_SEQ;
            RST_SEQ: begin
                state_nxt = (seq == SEQ_LAST) ? RUN : RST_SEQ;
                seq_nxt   = (seq == SEQ_LAST) ? 3'd0 : seq + 3'd1;
            end
            RUN:     state_nxt = RUN;
            default: state_nxt = RST_HOLD;
        endcase
    end

    // Status decode and the opcode-load / interrupt-selection strobes
    always_comb begin
        sync         = (state == RUN) && (cycle == 3'd0);
        reset_active = (state != RUN);
        load         = (state == RUN) && rdy && (cycle == 3'd0) && I_cycle;
        take_nmi     = load && nmi_pending;
        take_irq     = load && !nmi_pending && !irq_n && !I_flag;
    end

    // Cycle counter, instruction register and injection flags
    always_ff @(posedge clk_ph2)
        if (!rst) begin
            cycle      <= RESET_CYCLE;
            IR         <= BRK_OP;
            int_inject <= 1'b0;
            vec_sel    <= VEC_RESET;
        end else if (rdy) begin
            if (state != RUN)
                cycle <= (state == RST_SEQ && seq == SEQ_LAST) ? 3'd0 : RESET_CYCLE;
            else
                cycle <= R_cycle ? 3'd0 : I_cycle ? cycle + 3'd1 : cycle;
            if (load) begin
                IR         <= (take_nmi || take_irq) ? BRK_OP : DL;
                int_inject <= take_nmi || take_irq;
                vec_sel    <= take_nmi ? VEC_NMI : take_irq ? VEC_IRQ : VEC_NONE;
            end
        end
endmodule

// File: tb/tb_timing_control.sv
// tb_timing_control: directed and randomized checks of timing_control against a behavioural model
module tb_timing_control;
    logic       clk_ph2 = 1'b0;
    logic       rst = 1'b0, I_cycle = 1'b0, R_cycle = 1'b0, rdy = 1'b1;
    logic       nmi_n = 1'b1, irq_n = 1'b1, I_flag = 1'b1;
    logic [7:0] DL = 8'h00;
    logic [2:0] cycle;
    logic [7:0] IR;
    logic       sync, int_inject, reset_active;
    logic [1:0] vec_sel;
    int         checks = 0, errors = 0;
    // model: rst_left = -1 held in reset, 6..1 edges of reset sequence remaining, 0 running
    int         m_rst_left = -1;
    logic [2:0] m_cycle = 3'd7;
    logic [7:0] m_ir = 8'h00;
    logic       m_inj = 1'b0, m_pend = 1'b0, m_nmi_prev = 1'b1;
    logic [1:0] m_vec = 2'b10;

    timing_control dut (
        .clk_ph2      (clk_ph2),
        .rst          (rst),
        .I_cycle      (I_cycle),
        .R_cycle      (R_cycle),
        .DL           (DL),
        .rdy          (rdy),
        .nmi_n        (nmi_n),
        .irq_n        (irq_n),
        .I_flag       (I_flag),
        .cycle        (cycle),
        .IR           (IR),
        .sync         (sync),
        .int_inject   (int_inject),
        .vec_sel      (vec_sel),
        .reset_active (reset_active)
    );

    always #5 clk_ph2 = ~clk_ph2;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        logic fell, took_nmi;
        if (!rst) begin
            m_rst_left = -1;
            m_cycle    = 3'd7;
            m_ir       = 8'h00;
            m_inj      = 1'b0;
            m_vec      = 2'b10;
            m_pend     = 1'b0;
            m_nmi_prev = 1'b1;
            return;
        end
        fell       = m_nmi_prev && !nmi_n;
        m_nmi_prev = nmi_n;
        took_nmi   = 1'b0;
        if (rdy) begin
            if (m_rst_left == -1) m_rst_left = 6;
            else if (m_rst_left > 0) begin
                m_rst_left--;
                if (m_rst_left == 0) m_cycle = 3'd0;
            end else begin
                if (m_cycle == 3'd0 && I_cycle) begin
                    if (m_pend) begin
                        m_ir = 8'h00; m_inj = 1'b1; m_vec = 2'b01; took_nmi = 1'b1;
                    end else if (!irq_n && !I_flag) begin
                        m_ir = 8'h00; m_inj = 1'b1; m_vec = 2'b11;
                    end else begin
                        m_ir = DL; m_inj = 1'b0; m_vec = 2'b00;
                    end
                end
                if (R_cycle) m_cycle = 3'd0;
                else if (I_cycle) m_cycle = m_cycle + 3'd1;
            end
        end
        if (took_nmi) m_pend = 1'b0;
        if (fell) m_pend = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk_ph2);
        model_step();
        #1;
        chk("cycle", 8'(cycle), 8'(m_cycle));
        chk("IR", IR, m_ir);
        chk("int_inject", 8'(int_inject), 8'(m_inj));
        chk("vec_sel", 8'(vec_sel), 8'(m_vec));
        chk("reset_active", 8'(reset_active), 8'(m_rst_left != 0));
        chk("sync", 8'(sync), 8'(m_rst_left == 0 && m_cycle == 3'd0));
    endtask

    // bring cycle back to 0 without loading, then perform one opcode load
    task automatic load();
        R_cycle = 1'b1; I_cycle = 1'b0;
        tick();
        R_cycle = 1'b0; I_cycle = 1'b1;
        tick();
        I_cycle = 1'b0;
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_cycle", 8'(cycle), 8'd7);
        chk("rst_ir", IR, 8'h00);
        chk("rst_vec", 8'(vec_sel), 8'd2);
        chk("rst_sync", 8'(sync), 8'd0);
        chk("rst_active", 8'(reset_active), 8'd1);
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("seq_active", 8'(reset_active), 8'd1);
            chk("seq_vec", 8'(vec_sel), 8'd2);
        end
        tick();
        chk("run_cycle", 8'(cycle), 8'd0);
        chk("run_sync", 8'(sync), 8'd1);
        DL = 8'h69; I_cycle = 1'b1;
        tick();
        chk("ld_ir", IR, 8'h69);
        chk("ld_cycle", 8'(cycle), 8'd1);
        I_cycle = 1'b0; R_cycle = 1'b1;
        tick();
        chk("r_cycle", 8'(cycle), 8'd0);
        I_cycle = 1'b1;
        tick();
        chk("ri_cycle", 8'(cycle), 8'd0);
        R_cycle = 1'b0;
        tick();
        tick();
        chk("at_cycle2", 8'(cycle), 8'd2);
        I_cycle = 1'b0; nmi_n = 1'b0;
        tick();
        nmi_n = 1'b1; R_cycle = 1'b1;
        tick();
        R_cycle = 1'b0; DL = 8'hE8; I_cycle = 1'b1;
        tick();
        chk("nmi_ir", IR, 8'h00);
        chk("nmi_inj", 8'(int_inject), 8'd1);
        chk("nmi_vec", 8'(vec_sel), 8'd1);
        load();
        chk("post_nmi_ir", IR, 8'hE8);
        chk("post_nmi_inj", 8'(int_inject), 8'd0);
        chk("post_nmi_vec", 8'(vec_sel), 8'd0);
        irq_n = 1'b0; I_flag = 1'b1; DL = 8'h4C;
        load();
        chk("masked_ir", IR, 8'h4C);
        chk("masked_inj", 8'(int_inject), 8'd0);
        nmi_n = 1'b0;
        tick();
        nmi_n = 1'b1; I_flag = 1'b0; DL = 8'h11;
        load();
        chk("both_vec", 8'(vec_sel), 8'd1);
        chk("both_ir", IR, 8'h00);
        load();
        chk("irq_vec", 8'(vec_sel), 8'd3);
        chk("irq_inj", 8'(int_inject), 8'd1);
        irq_n = 1'b1; I_flag = 1'b1; DL = 8'h22;
        rdy = 1'b0; I_cycle = 1'b1; nmi_n = 1'b0;
        tick();
        nmi_n = 1'b1;
        repeat (3) tick();
        chk("stall_cycle", 8'(cycle), 8'd1);
        chk("stall_ir", IR, 8'h00);
        rdy = 1'b1; I_cycle = 1'b0;
        load();
        chk("stall_nmi_vec", 8'(vec_sel), 8'd1);
        load();
        chk("stall_after_ir", IR, 8'h22);
        I_cycle = 1'b1;
        tick();
        chk("mid_cycle2", 8'(cycle), 8'd2);
        I_cycle = 1'b0; nmi_n = 1'b0;
        tick();
        nmi_n = 1'b1; rst = 1'b0;
        tick();
        chk("mid_rst_cycle", 8'(cycle), 8'd7);
        chk("mid_rst_ir", IR, 8'h00);
        chk("mid_rst_vec", 8'(vec_sel), 8'd2);
        rst = 1'b1; DL = 8'h5A;
        repeat (7) tick();
        load();
        chk("cleared_nmi_vec", 8'(vec_sel), 8'd0);
        chk("cleared_nmi_ir", IR, 8'h5A);
        for (int i = 0; i < 3000; i++) begin
            rst     = ($urandom_range(0, 99) != 0);
            rdy     = ($urandom_range(0, 3) != 0);
            I_cycle = 1'($urandom);
            R_cycle = ($urandom_range(0, 7) == 0);
            nmi_n   = ($urandom_range(0, 9) != 0);
            irq_n   = 1'($urandom);
            I_flag  = 1'($urandom);
            DL      = 8'($urandom);
            tick();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
